// File: rtl/ps2_kbd_encoder.sv
// PS/2 keyboard device emulator: joystick bit changes become set-2 make/break frames on
// open-drain clock/data. Define KBD_TYPEMATIC_EN to auto-repeat the last held key.
module ps2_kbd_encoder #(
    parameter int CLK_DIV  = 1000,
    parameter int GAP_CYC  = 2000,
    parameter int INH_HOLD = 2000
`ifdef KBD_TYPEMATIC_EN
    ,
    parameter int TM_DELAY = 12000000,
    parameter int TM_RATE  = 2400000
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] joystick,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    output logic       busy,
    output logic       byte_sent
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_START, S_SETUP, S_LOW, S_HIGH, S_GAP, S_INHIBIT
    } state_t;

    localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYC - 1);
    localparam logic [31:0] INH_LAST = 32'(INH_HOLD - 1);
    localparam logic [3:0]  STOP_BIT = 4'd10;

    state_t      state_q, state_d;
    logic [7:0]  reported_q;
    logic [2:0]  key_q;
    logic        tgt_q;
    logic [23:0] list_q;
    logic [1:0]  len_q;
    logic [1:0]  idx_q;
    logic [3:0]  bit_q;
    logic [31:0] cnt_q;
    logic        byte_sent_q;

    logic [7:0]  diff;
    logic [2:0]  sel_key;
    logic        sel_tgt;
    logic        sel_valid;
    logic [7:0]  sel_code;
    logic        div_done, gap_done, inh_done, last_entry;
    logic        tm_fire;
    logic [7:0]  cur_byte;
    logic        frame_bit;

`ifdef KBD_TYPEMATIC_EN
    logic [2:0]  tm_key_q;
    logic        tm_valid_q;
    logic        tm_first_q;
    logic [31:0] tm_cnt_q;
`endif

    function automatic logic [7:0] key_code(input logic [2:0] k);
        case (k)
            3'd0:    return 8'h29;
            3'd1:    return 8'h16;
            3'd2:    return 8'h1E;
            3'd3:    return 8'h76;
            3'd4:    return 8'h75;
            3'd5:    return 8'h72;
            3'd6:    return 8'h6B;
            default: return 8'h74;
        endcase
    endfunction

    // Lowest changed bit wins; with nothing pending the repeat key (if any) is chosen.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        diff    = joystick ^ reported_q;
        sel_key = '0;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) sel_key = 3'(i);
        end
        sel_valid = (diff != '0);
`ifdef KBD_TYPEMATIC_EN
        if (diff == '0) begin
            sel_key   = tm_key_q;
            sel_valid = tm_valid_q;
        end
`endif
        sel_tgt  = joystick[sel_key];
        sel_code = key_code(sel_key);
    end

    always_comb begin
        div_done   = (cnt_q == DIV_LAST);
        gap_done   = (cnt_q == GAP_LAST);
        inh_done   = ps2_clk_in && (cnt_q == INH_LAST);
        last_entry = (idx_q == (len_q - 2'd1));
        case (idx_q)
            2'd0:    cur_byte = list_q[7:0];
            2'd1:    cur_byte = list_q[15:8];
            default: cur_byte = list_q[23:16];
        endcase
        case (bit_q)
            4'd0:    frame_bit = 1'b0;
            4'd9:    frame_bit = ~^cur_byte;
            4'd10:   frame_bit = 1'b1;
            default: frame_bit = cur_byte[3'(bit_q - 4'd1)];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of process ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (diff != '0 || tm_fire) state_d = S_SELECT;
            S_SELECT:  state_d = sel_valid ? S_START : S_IDLE;
            S_START:   state_d = ps2_clk_in ? S_SETUP : S_INHIBIT;
            S_SETUP: begin
                if (!ps2_clk_in)   state_d = S_INHIBIT;
                else if (div_done) state_d = S_LOW;
            end
            S_LOW:     if (div_done) state_d = (bit_q == STOP_BIT) ? S_GAP : S_HIGH;
            S_HIGH: begin
                if (!ps2_clk_in)   state_d = S_INHIBIT;
                else if (div_done) state_d = S_SETUP;
            end
            S_GAP:     if (gap_done) state_d = last_entry ? S_IDLE : S_START;
            S_INHIBIT: if (inh_done) state_d = S_SETUP;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ps2_clk_out  = 1'b1;
        ps2_data_out = 1'b1;
        busy         = (state_q != S_IDLE);
        byte_sent    = byte_sent_q;
        case (state_q)
            S_SETUP, S_HIGH: ps2_data_out = frame_bit;
            S_LOW: begin
                ps2_clk_out  = 1'b0;
                ps2_data_out = frame_bit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reported_q  <= '0;
            key_q       <= '0;
            tgt_q       <= 1'b0;
            list_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            byte_sent_q <= 1'b0;
        end else begin
            byte_sent_q <= (state_q == S_LOW) && div_done && (bit_q == STOP_BIT);

            // The inhibit counter measures a continuous high stretch, so any low restarts it.
            if (state_d != state_q || (state_q == S_INHIBIT && !ps2_clk_in))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 32'd1;

            if (state_q == S_START || state_q == S_INHIBIT)
                bit_q <= '0;
            else if (state_q == S_HIGH && state_d == S_SETUP)
                bit_q <= bit_q + 4'd1;

            if (state_q == S_SELECT) begin
                key_q <= sel_key;
                tgt_q <= sel_tgt;
                idx_q <= '0;
                case ({sel_key[2], sel_tgt})
                    2'b01: begin list_q <= {16'h0000, sel_code};        len_q <= 2'd1; end
                    2'b11: begin list_q <= {8'h00, sel_code, 8'hE0};     len_q <= 2'd2; end
                    2'b00: begin list_q <= {8'h00, sel_code, 8'hF0};     len_q <= 2'd2; end
                    default: begin list_q <= {sel_code, 8'hF0, 8'hE0};   len_q <= 2'd3; end
                endcase
            end

            if (state_q == S_GAP && gap_done) begin
                if (last_entry) reported_q[key_q] <= tgt_q;
                else            idx_q <= idx_q + 2'd1;
            end
        end
    end

`ifdef KBD_TYPEMATIC_EN
    always_comb begin
        tm_fire = (state_q == S_IDLE) && tm_valid_q && (diff == '0) &&
                  (tm_cnt_q == (tm_first_q ? 32'(TM_DELAY - 1) : 32'(TM_RATE - 1)));
    end

    // A finished make arms the repeat; a finished break or a different key disarms/rearms it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_key_q   <= '0;
            tm_valid_q <= 1'b0;
            tm_first_q <= 1'b0;
            tm_cnt_q   <= '0;
        end else begin
            if (state_q == S_GAP && gap_done && last_entry) begin
                tm_valid_q <= tgt_q;
                tm_first_q <= !(tm_valid_q && tm_key_q == key_q);
                tm_key_q   <= key_q;
            end
            if (state_q != S_IDLE || diff != '0)
                tm_cnt_q <= '0;
            else if (tm_valid_q)
                tm_cnt_q <= tm_cnt_q + 32'd1;
        end
    end
`else
    always_comb tm_fire = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_encoder.sv
// Directed bench for ps2_kbd_encoder: a line monitor decodes frames on falling PS/2
// clock edges, and each test compares them with hand-computed bytes and parities.
module tb_ps2_kbd_encoder;

    localparam int CLK_DIV  = 4;
    localparam int GAP_CYC  = 12;
    localparam int INH_HOLD = 20;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       host_clk = 1'b1;
    logic [7:0] joystick = 8'h00;
    logic       ps2_clk_in;
    logic       ps2_clk_out;
    logic       ps2_data_out;
    logic       busy;
    logic       byte_sent;

    // Host side of the wired-AND clock line.
    assign ps2_clk_in = ps2_clk_out & host_clk;

    always #5 clk = ~clk;

    ps2_kbd_encoder #(
        .CLK_DIV  (CLK_DIV),
        .GAP_CYC  (GAP_CYC),
        .INH_HOLD (INH_HOLD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .joystick     (joystick),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .busy         (busy),
        .byte_sent    (byte_sent)
    );

    int checks = 0;
    int errors = 0;

    int          bit_n, falls, lows, bad_lows, sent, busy_cyc, drops;
    int          idle_run, last_idle, start_idle, low_run;
    logic        prev_clk = 1'b1;
    logic [10:0] shift;
    logic [10:0] frames[$];
    int          gaps[$];

    // Line monitor: samples on the falling system clock, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            bit_n    = 0;
            prev_clk = 1'b1;
            low_run  = 0;
            idle_run = 0;
        end else begin
            if (ps2_clk_out && ps2_data_out) begin
                idle_run++;
                if (idle_run > 2 * CLK_DIV + 1 && bit_n != 0) begin
                    drops++;
                    bit_n = 0;
                end
            end else if (idle_run != 0) begin
                last_idle = idle_run;
                idle_run  = 0;
            end
            if (prev_clk && !ps2_clk_out) begin
                if (bit_n == 0) start_idle = last_idle;
                shift[bit_n] = ps2_data_out;
                bit_n++;
                falls++;
                if (bit_n == 11) begin
                    frames.push_back(shift);
                    gaps.push_back(start_idle);
                    bit_n = 0;
                end
            end
            if (!ps2_clk_out) low_run++;
            else if (!prev_clk) begin
                lows++;
                if (low_run != CLK_DIV) bad_lows++;
                low_run = 0;
            end
            if (byte_sent) sent++;
            if (busy) busy_cyc++;
            prev_clk = ps2_clk_out;
        end
    end

    function automatic logic [10:0] frm(input logic [7:0] b, input logic par);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Waits for a sequence to start and then for busy to stay low for 4 cycles.
    task automatic wait_quiet(input int budget, output bit ok);
        int  quiet = 0;
        bit  seen  = 0;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (busy) begin
                seen  = 1;
                quiet = 0;
            end else begin
                quiet++;
            end
            if (seen && quiet >= 4) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        joystick = 8'h00;
        host_clk = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ps2_clk_out !== 1'b1) begin errors++; $display("FAIL reset clk_out got %b want 1", ps2_clk_out); end
        checks++;
        if (ps2_data_out !== 1'b1) begin errors++; $display("FAIL reset data_out got %b want 1", ps2_data_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        checks++;
        if (byte_sent !== 1'b0) begin errors++; $display("FAIL reset byte_sent got %b want 0", byte_sent); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post-reset busy got %b want 0", busy); end
    endtask

    task automatic test_make_29();
        int f0 = frames.size(), fl0 = falls, l0 = lows, b0 = bad_lows, s0 = sent, bc0 = busy_cyc;
        bit ok;
        joystick = 8'h01;
        wait_quiet(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL make29 timeout got busy=%b want sequence done", busy); end
        checks++;
        if (frames.size() - f0 != 1) begin
            errors++; $display("FAIL make29 frames got %0d want 1", frames.size() - f0);
        end else begin
            checks++;
            if (frames[f0] !== 11'b100_0101_0010) begin
                errors++; $display("FAIL make29 frame got %b want 10001010010", frames[f0]);
            end
        end
        checks++;
        if (falls - fl0 != 11) begin errors++; $display("FAIL make29 clk falls got %0d want 11", falls - fl0); end
        checks++;
        if (lows - l0 != 11 || bad_lows != b0) begin
            errors++; $display("FAIL make29 low pulses got %0d (bad %0d) want 11 (bad 0)", lows - l0, bad_lows - b0);
        end
        checks++;
        if (sent - s0 != 1) begin errors++; $display("FAIL make29 byte_sent got %0d want 1", sent - s0); end
        checks++;
        if (busy_cyc - bc0 != 142) begin errors++; $display("FAIL make29 busy cycles got %0d want 142", busy_cyc - bc0); end
    endtask

    task automatic test_break_29();
        int f0 = frames.size(), s0 = sent;
        logic [10:0] exp[$];
        bit ok;
        exp = '{frm(8'hF0, 1'b1), frm(8'h29, 1'b0)};
        joystick = 8'h00;
        wait_quiet(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL break29 timeout got busy=%b want sequence done", busy); end
        checks++;
        if (frames.size() - f0 != exp.size()) begin
            errors++; $display("FAIL break29 frames got %0d want %0d", frames.size() - f0, exp.size());
        end else begin
            foreach (exp[k]) begin
                checks++;
                if (frames[f0 + k] !== exp[k]) begin
                    errors++; $display("FAIL break29 frame%0d got %b want %b", k, frames[f0 + k], exp[k]);
                end
            end
            checks++;
            if (gaps[f0 + 1] < GAP_CYC) begin errors++; $display("FAIL break29 gap got %0d want >=%0d", gaps[f0 + 1], GAP_CYC); end
        end
        checks++;
        if (sent - s0 != 2) begin errors++; $display("FAIL break29 byte_sent got %0d want 2", sent - s0); end
    endtask

    task automatic test_up_key();
        int f0;
        logic [10:0] exp[$];
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            f0 = frames.size();
            if (pass == 0) begin
                exp = '{frm(8'hE0, 1'b0), frm(8'h75, 1'b0)};
                joystick = 8'h10;
            end else begin
                exp = '{frm(8'hE0, 1'b0), frm(8'hF0, 1'b1), frm(8'h75, 1'b0)};
                joystick = 8'h00;
            end
            wait_quiet(3000, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL up pass%0d timeout got busy=%b want done", pass, busy); end
            checks++;
            if (frames.size() - f0 != exp.size()) begin
                errors++; $display("FAIL up pass%0d frames got %0d want %0d", pass, frames.size() - f0, exp.size());
            end else begin
                foreach (exp[k]) begin
                    checks++;
                    if (frames[f0 + k] !== exp[k]) begin
                        errors++; $display("FAIL up pass%0d frame%0d got %b want %b", pass, k, frames[f0 + k], exp[k]);
                    end
                    if (k > 0) begin
                        checks++;
                        if (gaps[f0 + k] < GAP_CYC) begin
                            errors++; $display("FAIL up pass%0d gap%0d got %0d want >=%0d", pass, k, gaps[f0 + k], GAP_CYC);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int f0 = frames.size();
        logic [10:0] exp[$];
        bit ok;
        exp = '{frm(8'h16, 1'b0), frm(8'h1E, 1'b1)};
        joystick = 8'h06;
        wait_quiet(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b timeout got busy=%b want done", busy); end
        checks++;
        if (frames.size() - f0 != exp.size()) begin
            errors++; $display("FAIL b2b frames got %0d want %0d", frames.size() - f0, exp.size());
        end else begin
            foreach (exp[k]) begin
                checks++;
                if (frames[f0 + k] !== exp[k]) begin
                    errors++; $display("FAIL b2b frame%0d got %b want %b", k, frames[f0 + k], exp[k]);
                end
            end
        end
        // With both bits reported nothing further should be sent.
        f0 = frames.size();
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frames.size() != f0) begin
            errors++; $display("FAIL b2b settled got busy=%b frames=%0d want busy=0 frames=0", busy, frames.size() - f0);
        end
        exp = '{frm(8'hF0, 1'b1), frm(8'h16, 1'b0), frm(8'hF0, 1'b1), frm(8'h1E, 1'b1)};
        joystick = 8'h00;
        wait_quiet(4000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b release timeout got busy=%b want done", busy); end
        checks++;
        if (frames.size() - f0 != exp.size()) begin
            errors++; $display("FAIL b2b release frames got %0d want %0d", frames.size() - f0, exp.size());
        end else begin
            foreach (exp[k]) begin
                checks++;
                if (frames[f0 + k] !== exp[k]) begin
                    errors++; $display("FAIL b2b release frame%0d got %b want %b", k, frames[f0 + k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_inhibit();
        int f0 = frames.size(), s0 = sent, d0 = drops;
        bit ok = 0;
        joystick = 8'h01;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bit_n == 4 && ps2_clk_out) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL inhibit reach bit4 got bit_n=%0d want 4", bit_n); end
        host_clk = 1'b0;
        @(negedge clk);
        checks++;
        if ({ps2_clk_out, ps2_data_out} !== 2'b11) begin
            errors++; $display("FAIL inhibit release got clk=%b data=%b want 1 1", ps2_clk_out, ps2_data_out);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sent != s0) begin
            errors++; $display("FAIL inhibit hold got busy=%b sent=%0d want busy=1 sent=0", busy, sent - s0);
        end
        host_clk = 1'b1;
        wait_quiet(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL inhibit retry timeout got busy=%b want done", busy); end
        checks++;
        if (drops - d0 != 1) begin errors++; $display("FAIL inhibit aborted frames got %0d want 1", drops - d0); end
        checks++;
        if (sent - s0 != 1) begin errors++; $display("FAIL inhibit byte_sent got %0d want 1", sent - s0); end
        checks++;
        if (frames.size() - f0 != 1) begin
            errors++; $display("FAIL inhibit frames got %0d want 1", frames.size() - f0);
        end else begin
            checks++;
            if (frames[f0] !== frm(8'h29, 1'b0)) begin
                errors++; $display("FAIL inhibit frame got %b want %b", frames[f0], frm(8'h29, 1'b0));
            end
            checks++;
            if (gaps[f0] < INH_HOLD) begin
                errors++; $display("FAIL inhibit retry delay got %0d want >=%0d", gaps[f0], INH_HOLD);
            end
        end
    endtask

    task automatic test_prestart_inhibit();
        int f0 = frames.size(), fl0 = falls;
        logic [10:0] exp[$];
        bit ok;
        exp = '{frm(8'hF0, 1'b1), frm(8'h29, 1'b0)};
        host_clk = 1'b0;
        joystick = 8'h00;
        repeat (60) @(negedge clk);
        checks++;
        if (falls != fl0 || busy !== 1'b1) begin
            errors++; $display("FAIL prestart held got falls=%0d busy=%b want falls=0 busy=1", falls - fl0, busy);
        end
        host_clk = 1'b1;
        wait_quiet(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL prestart timeout got busy=%b want done", busy); end
        checks++;
        if (frames.size() - f0 != exp.size()) begin
            errors++; $display("FAIL prestart frames got %0d want %0d", frames.size() - f0, exp.size());
        end else begin
            foreach (exp[k]) begin
                checks++;
                if (frames[f0 + k] !== exp[k]) begin
                    errors++; $display("FAIL prestart frame%0d got %b want %b", k, frames[f0 + k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int f0, s0;
        bit ok = 0;
        joystick = 8'h01;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bit_n == 3 && !ps2_clk_out) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid reach bit3 got bit_n=%0d want 3", bit_n); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_out, ps2_data_out, busy, byte_sent} !== 4'b1100) begin
            errors++; $display("FAIL rstmid outputs got %b want 1100", {ps2_clk_out, ps2_data_out, busy, byte_sent});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        f0 = frames.size();
        s0 = sent;
        wait_quiet(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid resend timeout got busy=%b want done", busy); end
        checks++;
        if (sent - s0 != 1) begin errors++; $display("FAIL rstmid byte_sent got %0d want 1", sent - s0); end
        checks++;
        if (frames.size() - f0 != 1) begin
            errors++; $display("FAIL rstmid frames got %0d want 1", frames.size() - f0);
        end else begin
            checks++;
            if (frames[f0] !== frm(8'h29, 1'b0)) begin
                errors++; $display("FAIL rstmid frame got %b want %b", frames[f0], frm(8'h29, 1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_29();
        test_break_29();
        test_up_key();
        test_back_to_back();
        test_inhibit();
        test_prestart_inhibit();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_kbd_encoder.md
Name: ps2_kbd_encoder

Overview:
- Emulates the device end of a PS/2 keyboard link.
- Watches an 8-bit joystick/button vector, turns each bit change into the matching set-2 make or break scan-code sequence, and serialises it as PS/2 device-to-host frames on open-drain clock/data.
- Uses: loopback-testing the keyboard decoder, and feeding on-board buttons into cores that expect a PS/2 keyboard.

Parameters:
- CLK_DIV, 1000: clk cycles per PS/2 clock half-period (1000 at 24 MHz gives 12 kHz).
- GAP_CYC, 2000: idle clk cycles forced between consecutive bytes.
- INH_HOLD, 2000: clk cycles ps2_clk_in must stay high after a host inhibit before a retry.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- joystick  in  8  button state: 1 = pressed, synchronous to clk.
- ps2_clk_in  in  1  sensed PS/2 clock line (wired-AND result).
- ps2_clk_out  out  1  0 = pull clock low, 1 = release.
- ps2_data_out  out  1  0 = pull data low, 1 = release.
- busy  out  1  a scan-code sequence is in progress.
- byte_sent  out  1  one-cycle pulse when a byte's stop bit completes.

Behaviour:
- Reset (reset_n low, any time, including mid-frame):
  - ps2_clk_out=1, ps2_data_out=1, busy=0, byte_sent=0.
  - reported[7:0]=0, all counters 0, FSM=IDLE.
- Key map, bit to code:
  - bit0 → 29, bit1 → 16, bit2 → 1E, bit3 → 76.
  - bit4 → E0 75, bit5 → E0 72, bit6 → E0 6B, bit7 → E0 74.
- Make sequence: [E0] code. Break sequence: [E0] F0 code.
- Sequencer FSM:
  - IDLE → SELECT when joystick != reported.
  - SELECT (1 cycle):
    - Pick the lowest index i with joystick[i] != reported[i].
    - Latch i and tgt=joystick[i].
    - Build a byte list of 1–3 entries; busy=1.
  - SEND: run the bit engine on the current list entry.
  - GAP: wait GAP_CYC cycles, then advance to the next entry.
  - After the last entry: reported[i]<=tgt, busy=0 → IDLE.
  - Bits changing during a sequence are handled by later SELECT passes. A bit that toggles back produces the opposite sequence; intermediate glitches are not reported.
- Bit engine, 11 bits per frame:
  - Frame order: start 0, D0..D7 LSB first, odd parity (data plus parity has an odd number of ones), stop 1.
  - Per bit: drive ps2_data_out while the clock is released and hold CLK_DIV cycles; ps2_clk_out=0 for CLK_DIV cycles; release for CLK_DIV cycles.
  - After the stop bit's low phase ends: release both lines and pulse byte_sent.
- Host inhibit:
  - Pre-start: if ps2_clk_in=0 before the start bit, the engine does not begin.
  - Mid-frame: if ps2_clk_in=0 while ps2_clk_out=1 at any point before the stop-bit low phase, abort. Release both lines and enter INHIBIT.
  - INHIBIT: wait until ps2_clk_in has been continuously high for INH_HOLD cycles, then resend the same byte from the start bit.
  - Inhibit during GAP or IDLE only delays the next start.
- No host-to-device command support. ps2_data_in is not sensed.

Optional Feature:
- KBD_TYPEMATIC_EN.
- When defined:
  - Adds parameters TM_DELAY (default 12000000) and TM_RATE (default 2400000).
  - If the last make sequence's key is still held and reported, with no pending change, re-issue its make sequence after TM_DELAY cycles, then every TM_RATE cycles.
  - Any other change, or release of that key, cancels the repeat. Pending changes always take priority over repeats.
- When undefined: no repeat logic; each press gives exactly one make sequence.

Test Plan:
- Reset, then joystick=01 → one frame of 0x29.
  - Data sampled on clock falling edges: 0,1,0,0,1,0,1,0,0,0,1 (parity 0).
  - Exactly 11 ps2_clk_out low pulses, each CLK_DIV long; byte_sent pulses once; busy high for the whole sequence.
- joystick 01 → 00 → bytes F0, 29. F0 parity bit = 1.
- joystick=10 (up) → E0, 75 with parity bits 0, 0. Release → E0, F0, 75. Bytes are separated by at least GAP_CYC released cycles.
- joystick 00 → 06 in the same cycle → 16 sent first, then 1E. reported ends at 06.
- Hold ps2_clk_in low during bit 4 of 0x29:
  - Lines release within 1 cycle.
  - Release ps2_clk_in → after INH_HOLD, the full 0x29 frame is re-sent.
  - No byte_sent pulse for the aborted attempt.
- Assert reset_n low mid-frame → both outputs 1 and busy 0 immediately. After release with joystick=01, a fresh 29 make sequence is sent.
